spider_controller: RTL and testbench

//  Owns the 4 spider enemies: spawn timing, descent, horizontal patrol, escape and death on hit.

---
 rtl/spider_controller_pkg.sv | 21 ++
 rtl/spider_controller_unit.sv | 83 ++++++++
 rtl/spider_controller.sv | 55 +++++
 tb/tb_spider_controller.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/spider_controller_pkg.sv
// spider_controller_pkg: shared constants, FSM states and LFSR step for the spider enemies
package spider_controller_pkg;
  localparam int N_SPIDER = 4;
  localparam int SCREEN_W = 640;
  localparam int SPRITE_W = 16;
  localparam int SPAWN_DELAY = 60;
  localparam int SPAWN_STAGGER = 30;
  localparam logic [9:0] X_MIN = 10'd32;
  localparam logic [9:0] X_MAX = 10'(SCREEN_W - SPRITE_W);
  localparam logic [9:0] PATROL_Y = 10'd64;
  localparam logic [9:0] BOTTOM_Y = 10'd440;
  localparam logic [9:0] H_SPEED = 10'd2;
  localparam logic [9:0] DROP_SPEED = 10'd1;
  localparam logic [9:0] STEP_DOWN = 10'd16;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  typedef enum logic [1:0] {ST_WAIT = 2'd0, ST_DROP = 2'd1, ST_PATROL = 2'd2} state_t;
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction
endpackage

// File: rtl/spider_controller_unit.sv
// spider_controller_unit: one spider's wait/drop/patrol FSM with position, direction and respawn counter
module spider_controller_unit
  import spider_controller_pkg::*;
#(
  parameter logic [7:0] INIT_CNT = 8'd60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_tick,
  input  logic       i_hit,
  input  logic       i_spawn_grant,
  input  logic [9:0] i_spawn_x,
  input  logic       i_spawn_dir,
  output logic       o_pending,
  output logic [9:0] o_x,
  output logic [9:0] o_y,
  output logic       o_alive,
  output logic       o_escaped
);
  state_t     r_state;
  logic [9:0] r_x, r_y;
  logic [7:0] r_cnt;
  logic       r_dir, r_alive, r_escaped;
  logic       w_bounce;
  logic [9:0] w_px, w_py, w_dy;
  // dir 0 = moving right, 1 = moving left; a bounce holds x and steps down instead
  assign w_bounce = r_dir ? (r_x < X_MIN + H_SPEED) : (r_x + H_SPEED > X_MAX);
  assign w_px = w_bounce ? r_x : (r_dir ? r_x - H_SPEED : r_x + H_SPEED);
  assign w_py = w_bounce ? r_y + STEP_DOWN : r_y;
  assign w_dy = r_y + DROP_SPEED;
  // spider FSM: a hit pre-empts any tick activity, including an escape on the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_WAIT;
      r_x <= '0;
      r_y <= '0;
      r_dir <= 1'b0;
      r_cnt <= INIT_CNT;
      r_alive <= 1'b0;
      r_escaped <= 1'b0;
    end else begin
      r_escaped <= 1'b0;
      if (i_hit && r_alive) begin
        r_alive <= 1'b0;
        r_state <= ST_WAIT;
        r_cnt <= 8'(SPAWN_DELAY);
      end else if (i_tick) begin
        case (r_state)
          ST_WAIT:
            if (r_cnt != 8'd0) r_cnt <= r_cnt - 8'd1;
            else if (i_spawn_grant) begin
              r_x <= i_spawn_x;
              r_y <= '0;
              r_dir <= i_spawn_dir;
              r_alive <= 1'b1;
              r_state <= ST_DROP;
            end
          ST_DROP: begin
            r_y <= w_dy;
            if (w_dy >= PATROL_Y) r_state <= ST_PATROL;
          end
          ST_PATROL: begin
            r_x <= w_px;
            r_y <= w_py;
            r_dir <= r_dir ^ w_bounce;
            if (w_py >= BOTTOM_Y) begin
              r_alive <= 1'b0;
              r_escaped <= 1'b1;
              r_cnt <= 8'(SPAWN_DELAY);
              r_state <= ST_WAIT;
            end
          end
          default: r_state <= ST_WAIT;
        endcase
      end
    end
  end
  assign o_pending = (r_state == ST_WAIT) && (r_cnt == 8'd0);
  assign o_x = r_x;
  assign o_y = r_y;
  assign o_alive = r_alive;
  assign o_escaped = r_escaped;
endmodule

// File: rtl/spider_controller.sv
// spider_controller: spawn LFSR, lowest-index spawn arbiter, spider instances, bus packing and event pulses
module spider_controller
  import spider_controller_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     game_en,
  input  logic                     frame_tick,
  input  logic [N_SPIDER-1:0]      hit_flat,
  output logic [N_SPIDER*10-1:0]   spider_x_flat,
  output logic [N_SPIDER*10-1:0]   spider_y_flat,
  output logic [N_SPIDER-1:0]      spider_alive_flat,
  output logic                     kill_pulse,
  output logic                     escape_pulse
);
  logic [15:0]         r_lfsr;
  logic                r_kill;
  logic                w_tick;
  logic [N_SPIDER-1:0] w_hit, w_pending, w_grant, w_escaped;
  logic [9:0]          w_spawn_x;
  assign w_tick = frame_tick & game_en;
  assign w_hit = hit_flat & {N_SPIDER{game_en}};
  assign w_grant = w_pending & (~w_pending + N_SPIDER'(1));
  assign w_spawn_x = X_MIN + {1'b0, r_lfsr[8:0]};
  // spawn LFSR advances once per enabled tick; the spawn uses the value before the step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_lfsr <= LFSR_SEED;
    else if (w_tick) r_lfsr <= lfsr_next(r_lfsr);
  end
  // one kill pulse no matter how many live spiders were hit together
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_kill <= 1'b0;
    else r_kill <= |(w_hit & spider_alive_flat);
  end
  for (genvar i = 0; i < N_SPIDER; i++) begin : g_spider
    spider_controller_unit #(
      .INIT_CNT(8'(SPAWN_DELAY + i * SPAWN_STAGGER))
    ) u_spider (
      .clk          (clk),
      .rst          (rst),
      .i_tick       (w_tick),
      .i_hit        (w_hit[i]),
      .i_spawn_grant(w_grant[i]),
      .i_spawn_x    (w_spawn_x),
      .i_spawn_dir  (r_lfsr[9]),
      .o_pending    (w_pending[i]),
      .o_x          (spider_x_flat[i*10 +: 10]),
      .o_y          (spider_y_flat[i*10 +: 10]),
      .o_alive      (spider_alive_flat[i]),
      .o_escaped    (w_escaped[i])
    );
  end
  assign kill_pulse = r_kill;
  assign escape_pulse = |w_escaped;
endmodule

// File: tb/tb_spider_controller.sv
// tb_spider_controller: directed stimulus with a pulse scoreboard for spider_controller
module tb_spider_controller;
  logic        clk = 1'b0;
  logic        rst, game_en, frame_tick;
  logic [3:0]  hit_flat;
  logic [39:0] spider_x_flat, spider_y_flat;
  logic [3:0]  spider_alive_flat;
  logic        kill_pulse, escape_pulse;
  int          total = 0, bad = 0, n_ticks = 0;
  logic [3:0]  auto_mask = 4'b0000;
  logic [3:0]  kill_q[$];
  int          esc_q[$];

  always #5 clk = ~clk;

  spider_controller dut (
    .clk              (clk),
    .rst              (rst),
    .game_en          (game_en),
    .frame_tick       (frame_tick),
    .hit_flat         (hit_flat),
    .spider_x_flat    (spider_x_flat),
    .spider_y_flat    (spider_y_flat),
    .spider_alive_flat(spider_alive_flat),
    .kill_pulse       (kill_pulse),
    .escape_pulse     (escape_pulse)
  );

  function automatic logic [15:0] lfsr_at(input int n);
    logic [15:0] l = 16'hACE1;
    for (int i = 0; i < n; i++) l = l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
    return l;
  endfunction

  function automatic logic [9:0] xs(input int k);
    return spider_x_flat[k*10 +: 10];
  endfunction

  function automatic logic [9:0] ys(input int k);
    return spider_y_flat[k*10 +: 10];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (kill_pulse !== 1'b0) begin
        if (kill_q.size() == 0) check("unexpected kill_pulse", kill_pulse, 0);
        else check("kill clears alive", spider_alive_flat & kill_q.pop_front(), 0);
      end
      if (escape_pulse !== 1'b0) begin
        if (esc_q.size() == 0) check("unexpected escape_pulse", escape_pulse, 0);
        else begin
          int k;
          k = esc_q.pop_front();
          check("escape clears alive", spider_alive_flat[k], 0);
          check("escape y held", ys(k), 448);
        end
      end
    end
  end

  task automatic tick(input logic [3:0] h);
    frame_tick = 1'b1;
    hit_flat = h;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    hit_flat = 4'b0000;
    if (game_en) n_ticks++;
    @(posedge clk); #1;
    if (game_en && (spider_alive_flat & auto_mask) != 4'b0000) begin
      kill_q.push_back(spider_alive_flat & auto_mask);
      hit_flat = spider_alive_flat & auto_mask;
    end
    @(posedge clk); #1;
    hit_flat = 4'b0000;
    @(posedge clk); #1;
  endtask

  task automatic hit_only(input logic [3:0] h);
    hit_flat = h;
    @(posedge clk); #1;
    hit_flat = 4'b0000;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [15:0] l;
    logic [9:0]  sx0, ex, ey, bx;
    logic        sd0, bchk, chk_next, bdir, found;
    logic [39:0] snap_x, snap_y;
    logic [3:0]  snap_a, h;
    logic        dir[2], known[2], done[2], pa[2];
    logic [9:0]  px[2], py[2];
    rst = 1'b1; game_en = 1'b0; frame_tick = 1'b0; hit_flat = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    check("reset alive", spider_alive_flat, 0);
    check("reset x", spider_x_flat, 0);
    check("reset y", spider_y_flat, 0);
    rst = 1'b0;
    game_en = 1'b1;
    @(posedge clk); #1;
    check("reset kill_pulse", kill_pulse, 0);
    check("reset escape_pulse", escape_pulse, 0);

    repeat (60) tick(4'b0000);
    check("no spawn while counting", spider_alive_flat, 4'b0000);
    tick(4'b0000);
    l = lfsr_at(60);
    sx0 = 10'd32 + {1'b0, l[8:0]};
    sd0 = l[9];
    check("spawn0 alive", spider_alive_flat, 4'b0001);
    check("spawn0 x", xs(0), sx0);
    check("spawn0 y", ys(0), 0);
    repeat (29) tick(4'b0000);
    check("spider1 still waiting", spider_alive_flat, 4'b0001);
    tick(4'b0000);
    l = lfsr_at(90);
    check("spawn1 alive", spider_alive_flat, 4'b0011);
    check("spawn1 x", xs(1), 10'd32 + {1'b0, l[8:0]});

    while (n_ticks < 124) tick(4'b0000);
    check("drop y63", ys(0), 63);
    tick(4'b0000);
    check("drop ends y64", ys(0), 64);
    check("drop keeps x", xs(0), sx0);
    tick(4'b0000);
    ex = sd0 ? ((sx0 < 10'd34) ? sx0 : sx0 - 10'd2) : sx0 + 10'd2;
    ey = (sd0 && sx0 < 10'd34) ? 10'd80 : 10'd64;
    check("first patrol x", xs(0), ex);
    check("first patrol y", ys(0), ey);

    check("alive before hits", spider_alive_flat, 4'b0111);
    kill_q.push_back(4'b0101);
    hit_only(4'b0101);
    check("alive after double hit", spider_alive_flat, 4'b0010);
    hit_only(4'b0001);
    check("hit on waiting spider ignored", spider_alive_flat, 4'b0010);

    snap_x = spider_x_flat; snap_y = spider_y_flat; snap_a = spider_alive_flat;
    game_en = 1'b0;
    repeat (50) tick(4'b0000);
    tick(4'b0010);
    repeat (49) tick(4'b0000);
    check("freeze x", spider_x_flat, snap_x);
    check("freeze y", spider_y_flat, snap_y);
    check("freeze alive", spider_alive_flat, snap_a);
    game_en = 1'b1;

    repeat (60) tick(4'b0000);
    check("respawn not yet", spider_alive_flat, 4'b1010);
    tick(4'b0000);
    l = lfsr_at(n_ticks - 1);
    check("respawn0 first", spider_alive_flat, 4'b1011);
    check("respawn0 x", xs(0), 10'd32 + {1'b0, l[8:0]});
    tick(4'b0000);
    l = lfsr_at(n_ticks - 1);
    check("respawn2 next tick", spider_alive_flat, 4'b1111);
    check("respawn2 x", xs(2), 10'd32 + {1'b0, l[8:0]});

    auto_mask = 4'b1100;
    bchk = 1'b0; chk_next = 1'b0; bdir = 1'b0; bx = '0;
    for (int k = 0; k < 2; k++) begin
      dir[k] = 1'b0; known[k] = 1'b0; done[k] = 1'b0;
    end
    for (int t = 0; t < 12000 && !(done[0] && done[1]); t++) begin
      h = 4'b0000;
      for (int k = 0; k < 2; k++) begin
        if (!done[k] && spider_alive_flat[k] && known[k] && ys(k) == 10'd432 &&
            (dir[k] ? xs(k) < 10'd34 : xs(k) > 10'd622)) begin
          if (k == 0) esc_q.push_back(0);
          else begin
            h[1] = 1'b1;
            kill_q.push_back(4'b0010);
          end
          done[k] = 1'b1;
        end
        px[k] = xs(k); py[k] = ys(k); pa[k] = spider_alive_flat[k];
      end
      tick(h);
      if (done[1]) auto_mask[1] = 1'b1;
      for (int k = 0; k < 2; k++) begin
        if (!pa[k] && spider_alive_flat[k]) known[k] = 1'b0;
        if (pa[k] && spider_alive_flat[k] && py[k] >= 10'd64) begin
          if (xs(k) == px[k]) begin
            if (k == 0 && !bchk && known[0]) begin
              check("bounce y step", ys(0), py[0] + 10'd16);
              check("bounce at wall", (px[0] > 10'd622) || (px[0] < 10'd34), 1);
              bchk = 1'b1; chk_next = 1'b1; bdir = ~dir[0]; bx = px[0];
            end
            dir[k] = ~dir[k];
          end else begin
            if (k == 0 && chk_next) begin
              check("move after bounce", xs(0), bdir ? bx - 10'd2 : bx + 10'd2);
              chk_next = 1'b0;
            end
            dir[k] = xs(k) < px[k];
            known[k] = 1'b1;
          end
        end
      end
    end
    check("escape run finished in budget", done[0] && done[1], 1);

    if (spider_alive_flat[0]) begin
      kill_q.push_back(4'b0001);
      hit_only(4'b0001);
    end
    found = 1'b0;
    for (int t = 0; t < 200 && !found; t++) begin
      tick(4'b0000);
      found = spider_alive_flat[0] && ys(0) >= 10'd1 && ys(0) <= 10'd60;
    end
    check("spider0 reached drop", found, 1);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    check("async rst alive", spider_alive_flat, 0);
    check("async rst x", spider_x_flat, 0);
    check("async rst y", spider_y_flat, 0);
    check("async rst pulses", {kill_pulse, escape_pulse}, 0);
    check("kill scoreboard drained", kill_q.size(), 0);
    check("escape scoreboard drained", esc_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
